// File: rtl/ym3438_out_accum.sv
// rtl/ym3438_out_accum.sv - sums 24 MOL/MOR slots per frame into a 16-bit stereo PCM stream.
// YM3438_OUT_FIFO_EN selects a 4-entry output FIFO instead of a single holding register.
module ym3438_out_accum (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        slot_en,
  input  logic        frame_sync,
  input  logic [8:0]  MOL,
  input  logic [8:0]  MOR,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        clr_err,
  output logic        err_slot,
  output logic        err_ovf
);

  logic signed [9:0]  s_l, s_r;
  logic signed [13:0] acc_l, acc_r;
  logic [4:0]         slot_cnt;
  logic               armed;
  logic               sync, push, slot_bad, pop, full, accept, ovf_set;
  logic [15:0]        push_l, push_r;

  assign s_l = $signed({1'b0, MOL}) - 10'sd256;
  assign s_r = $signed({1'b0, MOR}) - 10'sd256;

  assign sync     = slot_en & frame_sync;
  assign push     = sync & armed & (slot_cnt == 5'd24);
  assign slot_bad = sync & armed & (slot_cnt != 5'd24);
  assign push_l   = {acc_l, 2'b00};
  assign push_r   = {acc_r, 2'b00};

  assign pop     = out_valid & out_ready;
  assign accept  = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  // A frame_sync restarts the sum with the current slot; slots before the first sync are ignored.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      acc_l    <= '0;
      acc_r    <= '0;
      slot_cnt <= '0;
      armed    <= 1'b0;
    end else if (slot_en) begin
      if (frame_sync) begin
        acc_l    <= {{4{s_l[9]}}, s_l};
        acc_r    <= {{4{s_r[9]}}, s_r};
        slot_cnt <= 5'd1;
        armed    <= 1'b1;
      end else if (armed) begin
        acc_l <= acc_l + {{4{s_l[9]}}, s_l};
        acc_r <= acc_r + {{4{s_r[9]}}, s_r};
        if (slot_cnt != 5'd31) slot_cnt <= slot_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      err_slot <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      err_slot <= slot_bad | (err_slot & ~clr_err);
      err_ovf  <= ovf_set | (err_ovf & ~clr_err);
    end
  end

`ifdef YM3438_OUT_FIFO_EN
  logic [15:0] mem_l [4];
  logic [15:0] mem_r [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;

  assign full      = (count == 3'd4);
  assign out_valid = (count != 3'd0);
  assign out_l     = mem_l[rd_ptr];
  assign out_r     = mem_r[rd_ptr];

  // Entries are cleared on reset so the head reads as zero while the FIFO is empty.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem_l[wr_ptr] <= push_l;
        mem_r[wr_ptr] <= push_r;
        wr_ptr        <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, accept} - {2'b00, pop};
    end
  end
`else
  assign full = out_valid;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_l     <= push_l;
      out_r     <= push_r;
      out_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/ym3438_out_accum.md
# ym3438_out_accum

Downstream stage of the OPN2 core: consumes the time-multiplexed 9-bit MOL/MOR channel slots and sums one full 24-slot frame per side into a signed 16-bit stereo PCM sample. It presents each completed sample on a valid/ready stream for the audio sink (I2S serializer or resampler). It sits between the core's output registers and the platform audio path, and runs on the core clock.

## Interface
- No parameters.
- MCLK  in  1  core master clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- slot_en  in  1  one-MCLK strobe when MOL/MOR hold a new slot value (one MCLK after c1 falls).
- frame_sync  in  1  frame marker (core TEST_o / sel23); sampled only when slot_en=1; marks the first slot of a frame.
- MOL  in  9  left slot value, offset binary, 9'h100 = zero.
- MOR  in  9  right slot value, offset binary.
- out_l  out  16  left PCM sample, signed two's complement.
- out_r  out  16  right PCM sample, signed.
- out_valid  out  1  sample available.
- out_ready  in  1  sink accepts when out_valid & out_ready on a posedge.
- clr_err  in  1  synchronous clear of the sticky flags.
- err_slot  out  1  sticky: a frame had a slot count other than 24.
- err_ovf  out  1  sticky: a completed frame was dropped because the output store was full.

## Operation
- Conversion per slot: s = {1'b0,MOx} - 9'd256, i.e. a 10-bit signed value in -256..+255.
- Accumulators acc_l/acc_r: 14-bit signed; a frame range of -6144..+6120 never overflows. slot_cnt: 5-bit, saturates at 31.
- armed flag: 0 after reset; set by the first slot_en&frame_sync.
- On slot_en & frame_sync:
  - if armed & slot_cnt==24, push {acc_l<<2, acc_r<<2} into the output store;
  - if armed & slot_cnt!=24, drop the frame and set err_slot;
  - in all cases acc := s of the current slot, slot_cnt := 1, armed := 1.
- On slot_en & ~frame_sync: if armed, acc += s and slot_cnt increments with saturation; if not armed, the slot is ignored.
- Scaling: the output is acc sign-extended to 16 bits, then shifted left 2. Maximum magnitude is 24576, so no saturation logic is needed.
- Push when the store is full and no pop occurs in the same cycle: the new sample is discarded, the stored samples are kept, and err_ovf is set.
- Push and pop in the same cycle on a full store: the push is accepted.
- clr_err clears both sticky flags. If a set event occurs in the same cycle as clr_err, the set wins.

## Timing
- Reset values: out_l = out_r = 0, out_valid = 0, err_slot = err_ovf = 0, acc = 0, slot_cnt = 0, armed = 0, store empty.
- Push latency: out_valid rises on the posedge following the frame_sync strobe edge.
- out_l/out_r are registered and stable while out_valid=1 & ~out_ready. After a pop, the next entry appears on the following edge.
- out_valid never drops without a pop, except on RESET.
- RESET asserted mid-frame discards the partial accumulation and the store contents. The first frame after release is never pushed.
- Nominal rate is one sample per 24 slot_en strobes (MCLK/144 with a /6 prescaler). The sink must pop within one frame unless YM3438_OUT_FIFO_EN is set.

## Configuration
- YM3438_OUT_FIFO_EN defined: the output store is a 4-entry FIFO. out_* shows the head entry. Full means 4 entries.
- YM3438_OUT_FIFO_EN undefined: the output store is a single holding register. Full means out_valid=1.
- Push/pop, drop, err_ovf and reset rules are identical in both builds; only the depth differs.

## Test plan
- Reset, then 3 frames of 24 slots with MOL=MOR=9'h100, out_ready=1 -> exactly 2 samples of 0/0 (first frame unarmed), no error flags.
- Frame of 24 slots with MOL=9'h1FF, MOR=9'h000 -> out_l=16'd24480, out_r=-16'd24576, with out_valid rising one MCLK after the next frame_sync strobe.
- Frame of 23 slots, then frame_sync -> no push, err_slot=1. The following 24-slot frame pushes normally. clr_err -> err_slot=0.
- out_ready=0 across 2 completed frames (6 in FIFO build) -> err_ovf=1, and out_l holds the first sample unchanged. Raise out_ready -> stored samples are delivered in order.
- Full store with out_ready=1 on the same cycle as the push -> old head popped, new sample accepted, err_ovf stays 0.
- Assert RESET for 1 MCLK mid-frame while out_valid=1 -> out_valid=0 immediately, out_l=out_r=0; the next frame_sync produces no sample.
